// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide unit for a MIPS-style pipeline.
// Multiplies finish after MUL_CYCLES cycles; divides use a 32-step restoring loop plus a sign-fix cycle.
module muldiv_sequencer #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic        i_hilo_read,
  input  logic        i_flush,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpMadd  = 4'd3;
  localparam logic [3:0] OpMaddu = 4'd4;
  localparam logic [3:0] OpMsub  = 4'd5;
  localparam logic [3:0] OpMsubu = 4'd6;
  localparam logic [3:0] OpDiv   = 4'd7;
  localparam logic [3:0] OpDivu  = 4'd8;
  localparam logic [3:0] OpMthi  = 4'd9;
  localparam logic [3:0] OpMtlo  = 4'd10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDivFix} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_op, w_op_nxt;
  logic [31:0] r_rs, w_rs_nxt;
  logic [31:0] r_rt, w_rt_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic        r_done, w_done_nxt;
  logic [31:0] r_rem, w_rem_nxt;
  logic [31:0] r_quo, w_quo_nxt;
  logic [31:0] r_dvs, w_dvs_nxt;

  logic        w_mul_signed;
  logic [63:0] w_a_ext, w_b_ext, w_prod, w_acc, w_mul_res;
  logic [32:0] w_rem_sh, w_sub;
  logic        w_ge;
  logic        w_q_neg, w_r_neg;
  logic [31:0] w_q_fix, w_r_fix;
  logic [31:0] w_rs_mag, w_rt_mag;

  // Sign-extended 64x64 product keeps the low 64 bits correct for both signednesses.
  assign w_mul_signed = (r_op == OpMult) || (r_op == OpMadd) || (r_op == OpMsub);
  assign w_a_ext      = w_mul_signed ? {{32{r_rs[31]}}, r_rs} : {32'b0, r_rs};
  assign w_b_ext      = w_mul_signed ? {{32{r_rt[31]}}, r_rt} : {32'b0, r_rt};
  assign w_prod       = w_a_ext * w_b_ext;
  assign w_acc        = {r_hi, r_lo};

  always_comb begin
    w_mul_res = w_prod;
    if (r_op == OpMadd || r_op == OpMaddu) w_mul_res = w_acc + w_prod;
    if (r_op == OpMsub || r_op == OpMsubu) w_mul_res = w_acc - w_prod;
  end

  // r_quo starts as the dividend magnitude and fills with quotient bits from the bottom.
  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_sub    = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_sub[32];

  assign w_q_neg = (r_op == OpDiv) && (r_rs[31] ^ r_rt[31]);
  assign w_r_neg = (r_op == OpDiv) && r_rs[31];
  assign w_q_fix = w_q_neg ? (32'd0 - r_quo) : r_quo;
  assign w_r_fix = w_r_neg ? (32'd0 - r_rem) : r_rem;

  assign w_rs_mag = (i_op == OpDiv && i_rs_val[31]) ? (32'd0 - i_rs_val) : i_rs_val;
  assign w_rt_mag = (i_op == OpDiv && i_rt_val[31]) ? (32'd0 - i_rt_val) : i_rt_val;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_rs_nxt    = r_rs;
    w_rt_nxt    = r_rt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_dvs_nxt   = r_dvs;
    if (i_flush) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_op_nxt = i_op;
            w_rs_nxt = i_rs_val;
            w_rt_nxt = i_rt_val;
            case (i_op)
              OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu: begin
                w_state_nxt = StMul;
                w_cnt_nxt   = 5'(MUL_CYCLES - 1);
              end
              OpDiv, OpDivu: begin
                w_state_nxt = StDiv;
                w_cnt_nxt   = 5'd31;
                w_rem_nxt   = 32'd0;
                w_quo_nxt   = w_rs_mag;
                w_dvs_nxt   = w_rt_mag;
              end
              OpMthi: begin
                w_hi_nxt   = i_rs_val;
                w_done_nxt = 1'b1;
              end
              OpMtlo: begin
                w_lo_nxt   = i_rs_val;
                w_done_nxt = 1'b1;
              end
              default: ;
            endcase
          end
        end
        StMul: begin
          if (r_cnt == 5'd0) begin
            {w_hi_nxt, w_lo_nxt} = w_mul_res;
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_cnt_nxt = r_cnt - 5'd1;
          end
        end
        StDiv: begin
          w_rem_nxt = w_ge ? w_sub[31:0] : w_rem_sh[31:0];
          w_quo_nxt = {r_quo[30:0], w_ge};
          if (r_cnt == 5'd0) w_state_nxt = StDivFix;
          else               w_cnt_nxt   = r_cnt - 5'd1;
        end
        StDivFix: begin
          if (r_rt == 32'd0) begin
            w_hi_nxt = r_rs;
            w_lo_nxt = 32'hFFFF_FFFF;
          end else begin
            w_hi_nxt = w_r_fix;
            w_lo_nxt = w_q_fix;
          end
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 5'd0;
      r_op    <= 4'd0;
      r_rs    <= 32'd0;
      r_rt    <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvs   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_rs    <= w_rs_nxt;
      r_rt    <= w_rt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_dvs   <= w_dvs_nxt;
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = (r_state != StIdle);
  assign o_stall = o_busy & (i_hilo_read | i_start);
  assign o_done  = r_done;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops against an
// arithmetic reference model of HI/LO.
module tb_muldiv_sequencer;

  localparam int MulCycles = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_read;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          exp_cyc;
  logic        exp_done;

  muldiv_sequencer #(.MUL_CYCLES(MulCycles)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_op        (op),
    .i_rs_val    (rs_val),
    .i_rt_val    (rt_val),
    .i_hilo_read (hilo_read),
    .i_flush     (flush),
    .o_hi        (hi),
    .o_lo        (lo),
    .o_busy      (busy),
    .o_stall     (stall),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: HI/LO effect of one op computed with plain integer arithmetic.
  task automatic model(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p, acc;
    int              si, ti;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {m_hi, m_lo};
    if (mop == 4'd1 || mop == 4'd3 || mop == 4'd5) p = sa * sb;
    else                                           p = ua * ub;
    exp_cyc  = 0;
    exp_done = 1'b1;
    case (mop)
      4'd1, 4'd2: begin {m_hi, m_lo} = p;       exp_cyc = MulCycles; end
      4'd3, 4'd4: begin {m_hi, m_lo} = acc + p; exp_cyc = MulCycles; end
      4'd5, 4'd6: begin {m_hi, m_lo} = acc - p; exp_cyc = MulCycles; end
      4'd7, 4'd8: begin
        exp_cyc = 33;
        if (b == 32'd0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else if (mop == 4'd8) begin
          m_lo = a / b;
          m_hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          si   = $signed(a);
          ti   = $signed(b);
          m_lo = 32'(si / ti);
          m_hi = 32'(si % ti);
        end
      end
      4'd9:    m_hi = a;
      4'd10:   m_lo = a;
      default: exp_done = 1'b0;
    endcase
  endtask

  task automatic issue(input logic [3:0] iop, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = iop;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = 4'd0;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Issue one op, optionally poke start while busy, then check occupancy, stall, done, HI/LO.
  task automatic run_op(input logic [3:0] rop, input logic [31:0] a, input logic [31:0] b,
                        input logic rd, input logic intrude);
    int cyc;
    int stall_cnt;
    int exp_stall;
    hilo_read = rd;
    model(rop, a, b);
    issue(rop, a, b);
    cyc       = 0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!busy || cyc > 100) break;
      cyc++;
      if (stall) stall_cnt++;
      if (intrude && cyc == 1) begin
        start  = 1'b1;
        op     = 4'($urandom_range(1, 10));
        rs_val = $urandom;
        rt_val = $urandom;
      end
      if (intrude && cyc == 2) start = 1'b0;
    end
    exp_stall = rd ? exp_cyc : ((intrude && exp_cyc >= 2) ? 1 : 0);
    chk("busy_cycles", 32'(cyc), 32'(exp_cyc));
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    chk("done_pulse", {31'd0, done}, {31'd0, exp_done});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(negedge clk);
    chk("done_clear", {31'd0, done}, 32'd0);
    hilo_read = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b1;
    op        = 4'd9;
    rs_val    = 32'h0000_00A5;
    rt_val    = 32'd0;
    hilo_read = 1'b1;
    flush     = 1'b0;

    // Reset state, with start and hilo_read held high.
    #3;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Start pending at release is honoured on the first rising edge.
    #19;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    hilo_read = 1'b0;
    m_hi      = 32'h0000_00A5;
    @(negedge clk);
    chk("first_edge_mthi", hi, 32'h0000_00A5);
    chk("first_edge_done", {31'd0, done}, 32'd1);

    // MULT -2 * 3.
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFFA);

    // MADDU on top of hi=0, lo=5.
    run_op(4'd9, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd10, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(4'd4, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("maddu_hi_const", hi, 32'd2);
    chk("maddu_lo_const", lo, 32'd3);

    // DIV -7 / 2 with hilo_read held: stall for all 33 cycles.
    run_op(4'd7, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);

    // Divide by zero and the overflow case.
    run_op(4'd8, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    chk("divu0_hi_const", hi, 32'h0000_1234);
    chk("divu0_lo_const", lo, 32'hFFFF_FFFF);
    run_op(4'd7, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
    run_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("divovf_lo_const", lo, 32'h8000_0000);

    // MTLO while idle, and a start while busy that must be ignored.
    run_op(4'd10, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    chk("mtlo_const", lo, 32'hCAFE_F00D);
    run_op(4'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
    chk("ignored_start_hi", hi, 32'd1);

    // Flush in DIV cycle 10.
    issue(4'd7, 32'd1000, 32'd7);
    for (int i = 1; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("flush_no_done", {31'd0, done}, 32'd0);
    end

    // Flush with start in IDLE: start is dropped.
    @(negedge clk);
    flush  = 1'b1;
    start  = 1'b1;
    op     = 4'd9;
    rs_val = 32'h1111_2222;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush_start_hi", hi, m_hi);
    chk("flush_start_done", {31'd0, done}, 32'd0);

    // Reset pulse in the middle of a MULT.
    issue(4'd1, 32'd7, 32'd9);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done}, 32'd0);
    end
    chk("midrst_hi_after", hi, 32'd0);

    // Random ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      logic [3:0]  rop;
      rop = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(rop, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
